// File: rtl/common_pkg.sv
// Shared scalar and machine-word typedefs for the pipeline blocks.
package common;

    typedef logic        u1;
    typedef logic [63:0] u64;

endpackage

// File: rtl/pipes_pkg.sv
// Trap-sequencer types, mcause codes and mstatus field positions, plus the
// mstatus rewrite helpers used on trap entry and on mret.
package pipes;

    import common::*;

    typedef enum logic [1:0] {
        EXCEPTION = 2'd0,
        EXTERNAL  = 2'd1,
        SOFTWARE  = 2'd2,
        TIMER     = 2'd3
    } interrupt_type;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        DRAIN       = 3'd1,
        COMMIT      = 3'd2,
        REDIRECT    = 3'd3,
        MRET_COMMIT = 3'd4
    } trap_state_t;

    localparam logic [3:0] CAUSE_EXTERNAL = 4'd11;
    localparam logic [3:0] CAUSE_SOFTWARE = 4'd3;
    localparam logic [3:0] CAUSE_TIMER    = 4'd7;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    localparam logic [1:0] PRIV_M              = 2'b11;
    localparam logic [1:0] MTVEC_MODE_VECTORED = 2'b01;

    // Trap entry stacks the interrupt enable and forces M-mode as previous privilege.
    function automatic u64 trap_mstatus(input u64 status);
        u64 result;
        result                               = status;
        result[MSTATUS_MPIE]                 = status[MSTATUS_MIE];
        result[MSTATUS_MIE]                  = 1'b0;
        result[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = PRIV_M;
        return result;
    endfunction

    function automatic u64 mret_mstatus(input u64 status);
        u64 result;
        result                               = status;
        result[MSTATUS_MIE]                  = status[MSTATUS_MPIE];
        result[MSTATUS_MPIE]                 = 1'b1;
        result[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = PRIV_M;
        return result;
    endfunction

endpackage

// File: rtl/trap_cause_encode.sv
// Combinational mcause encoder: interrupts set bit 63 with a fixed code,
// exceptions pass the 4-bit cause code through.
module trap_cause_encode
    import common::*;
    import pipes::*;
(
    input  interrupt_type trap_type_i,
    input  logic [3:0]    ex_code_i,
    output u64            mcause_o
);

    always_comb begin
        mcause_o = '0;
        unique case (trap_type_i)
            EXCEPTION: mcause_o = {60'd0, ex_code_i};
            EXTERNAL:  mcause_o = {1'b1, 59'd0, CAUSE_EXTERNAL};
            SOFTWARE:  mcause_o = {1'b1, 59'd0, CAUSE_SOFTWARE};
            TIMER:     mcause_o = {1'b1, 59'd0, CAUSE_TIMER};
            default:   mcause_o = '0;
        endcase
    end

endmodule

// File: rtl/trap_sequencer.sv
// Machine-mode trap/mret sequencer: drains the pipeline, writes mepc/mcause/mstatus
// and redirects fetch. Define VECTORED_MTVEC_EN to enable vectored interrupt targets.
module trap_sequencer
    import common::*;
    import pipes::*;
(
    input  u1             clk,
    input  u1             reset,
    input  u1             trap_valid,
    input  u64            trap_pc,
    input  interrupt_type trap_type,
    input  logic [3:0]    ex_code,
    input  u1             mret_valid,
    input  u64            mtvec,
    input  u64            mepc_in,
    input  u64            mstatus_in,
    input  u1             fetch_busy,
    input  u1             mem_busy,
    input  u1             redirect_ready,
    output u1             busy,
    output u1             flush,
    output u1             csr_we,
    output u64            mepc_out,
    output u64            mcause_out,
    output u64            mstatus_out,
    output u1             redirect_valid,
    output u64            redirect_pc
);

    trap_state_t   state_q, state_d;
    u64            trap_pc_q, trap_pc_d;
    interrupt_type trap_type_q, trap_type_d;
    logic [3:0]    ex_code_q, ex_code_d;
    u64            redirect_pc_q, redirect_pc_d;
    u64            mcause_w;
    u64            trap_target;

    trap_cause_encode u_cause_encode (
        .trap_type_i (trap_type_q),
        .ex_code_i   (ex_code_q),
        .mcause_o    (mcause_w)
    );

    // Masking rather than slicing keeps the mode bits referenced in either build.
    always_comb begin
        trap_target = mtvec & ~64'd3;
`ifdef VECTORED_MTVEC_EN
        if (mtvec[1:0] == MTVEC_MODE_VECTORED && mcause_w[63]) begin
            trap_target = trap_target + {58'd0, mcause_w[3:0], 2'b00};
        end
`endif
    end

    always_comb begin
        // NOTE: every _d and every output gets a default first, so no branch can infer a latch.
        state_d        = state_q;
        trap_pc_d      = trap_pc_q;
        trap_type_d    = trap_type_q;
        ex_code_d      = ex_code_q;
        redirect_pc_d  = redirect_pc_q;
        busy           = (state_q != IDLE);
        flush          = 1'b0;
        csr_we         = 1'b0;
        mepc_out       = '0;
        mcause_out     = '0;
        mstatus_out    = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;

        case (state_q)
            IDLE: begin
                if (trap_valid) begin
                    trap_pc_d   = trap_pc;
                    trap_type_d = trap_type;
                    ex_code_d   = ex_code;
                    state_d     = DRAIN;
                end else if (mret_valid) begin
                    state_d = MRET_COMMIT;
                end
            end
            DRAIN: begin
                flush = 1'b1;
                if (!fetch_busy && !mem_busy) begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                flush         = 1'b1;
                csr_we        = 1'b1;
                mepc_out      = trap_pc_q;
                mcause_out    = mcause_w;
                mstatus_out   = trap_mstatus(mstatus_in);
                redirect_pc_d = trap_target;
                state_d       = REDIRECT;
            end
            MRET_COMMIT: begin
                flush         = 1'b1;
                csr_we        = 1'b1;
                mepc_out      = mepc_in;
                mstatus_out   = mret_mstatus(mstatus_in);
                redirect_pc_d = mepc_in;
                state_d       = REDIRECT;
            end
            REDIRECT: begin
                redirect_valid = 1'b1;
                redirect_pc    = redirect_pc_q;
                if (redirect_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state updates use non-blocking assignments; reset is synchronous and clears every latched field.
        if (reset) begin
            state_q       <= IDLE;
            trap_pc_q     <= '0;
            trap_type_q   <= EXCEPTION;
            ex_code_q     <= '0;
            redirect_pc_q <= '0;
        end else begin
            state_q       <= state_d;
            trap_pc_q     <= trap_pc_d;
            trap_type_q   <= trap_type_d;
            ex_code_q     <= ex_code_d;
            redirect_pc_q <= redirect_pc_d;
        end
    end

endmodule

// File: doc/trap_sequencer.md
TRAP_SEQUENCER -- requirements
Module: trap_sequencer

Interface
REQ-001 SHALL: clk  in  1  single clock; all state updates on posedge clk.
REQ-002 SHALL: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL: trap_valid  in  1  trap request from interrupt_controller (level, held by source).
REQ-004 SHALL: trap_pc  in  64  return PC to save in mepc.
REQ-005 SHALL: trap_type  in  interrupt_type  EXCEPTION / EXTERNAL / SOFTWARE / TIMER.
REQ-006 SHALL: ex_code  in  4  exception cause code; valid only when trap_type==EXCEPTION.
REQ-007 SHALL: mret_valid  in  1  mret committed in W stage.
REQ-008 SHALL: mtvec, mepc_in, mstatus_in  in  64 each  current CSR values.
REQ-009 SHALL: fetch_busy, mem_busy  in  1 each  outstanding ibus/dbus transaction.
REQ-010 SHALL: redirect_ready  in  1  fetch accepts the redirect.
REQ-011 SHALL: busy  out  1  high in every state except IDLE.
REQ-012 SHALL: flush  out  1  flush all pipeline registers F..W.
REQ-013 SHALL: csr_we  out  1  write mepc/mcause/mstatus outputs this cycle.
REQ-014 SHALL: mepc_out, mcause_out, mstatus_out  out  64 each  CSR write data.
REQ-015 SHALL: redirect_valid  out  1; redirect_pc  out  64  new fetch PC.

Function
REQ-016 SHALL: FSM states IDLE, DRAIN, COMMIT, REDIRECT, MRET_COMMIT.
REQ-017 SHALL: IDLE + trap_valid -> latch trap_pc, trap_type, ex_code; go DRAIN; trap_valid wins over simultaneous mret_valid.
REQ-018 SHALL: IDLE + mret_valid (no trap) -> MRET_COMMIT.
REQ-019 SHALL: DRAIN: flush=1 every cycle; leave for COMMIT on first cycle with fetch_busy==0 and mem_busy==0; no timeout.
REQ-020 SHALL: COMMIT lasts exactly one cycle: csr_we=1, flush=1, mepc_out=latched pc, mcause_out and mstatus_out per REQ-022/023; next REDIRECT.
REQ-021 SHALL: REDIRECT: redirect_valid=1, redirect_pc stable until redirect_ready; return to IDLE in the cycle after redirect_ready is seen.
REQ-022 SHALL: mcause_out = {1'b1, 59'b0, code} for interrupts (EXTERNAL=11, SOFTWARE=3, TIMER=7), {60'b0, ex_code} for EXCEPTION.
REQ-023 SHALL: trap mstatus_out = mstatus_in with MPIE[7]<=MIE[3], MIE[3]<=0, MPP[12:11]<=2'b11.
REQ-024 SHALL: MRET_COMMIT lasts one cycle: csr_we=1, flush=1, mstatus_out = mstatus_in with MIE<=MPIE, MPIE<=1, MPP<=2'b11; mepc_out=mepc_in, mcause_out=0; next REDIRECT with redirect_pc=mepc_in latched.
REQ-025 SHALL: trap_valid/mret_valid ignored outside IDLE; new trap taken no earlier than the cycle after return to IDLE.
REQ-026 SHALL: redirect_pc for traps = {mtvec[63:2], 2'b00} unless vectoring applies (REQ-029).
REQ-027 SHALL: trap-entry latency with no bus busy = 3 cycles (DRAIN, COMMIT, REDIRECT) plus redirect_ready wait.

Reset
REQ-028 SHALL: reset (any state, including mid-DRAIN/REDIRECT) -> IDLE next cycle, latched fields 0, all outputs 0; pending request discarded.

Configuration
REQ-029 SHALL: VECTORED_MTVEC_EN defined -> when mtvec[1:0]==2'b01 and trap is an interrupt, redirect_pc = {mtvec[63:2],2'b00} + 4*code; exceptions always base. Undefined -> mtvec[1:0] ignored, always base.

Structure
REQ-030 SHALL: trap_state_t enum and cause-code constants (11/3/7) and mstatus bit-index constants live in package pipes; u1/u64 from common.
REQ-031 SHALL: one sub-module, trap_cause_encode (combinational: trap_type, ex_code -> mcause); rest in trap_sequencer.

Verification
REQ-032 SHALL: TIMER trap, pc=0x8000_0100, mtvec=0x8000_0000, mstatus=0x8, no busy -> DRAIN 1 cycle, COMMIT mcause=0x8000_0000_0000_0007, mepc=0x8000_0100, mstatus=0x1880; redirect_pc=0x8000_0000.
REQ-033 SHALL: EXCEPTION ex_code=2 with mem_busy high 5 cycles -> flush high 6 cycles in DRAIN, then mcause=0x2.
REQ-034 SHALL: mret, mepc_in=0x8000_0200, mstatus_in=0x1880 -> mstatus_out=0x1888, redirect_pc=0x8000_0200.
REQ-035 SHALL: trap_valid and mret_valid same cycle -> trap path taken, no MRET_COMMIT.
REQ-036 SHALL: reset asserted in REDIRECT with redirect_ready=0 -> next cycle busy=0, redirect_valid=0.
REQ-037 SHALL: VECTORED_MTVEC_EN, mtvec=0x8000_0001, EXTERNAL -> redirect_pc=0x8000_002C; without macro -> 0x8000_0000.
